// File: rtl/mlaccel_pkg.sv
// Shared widths, requester ids and the read-tag record for the memory arbiter.
package mlaccel_pkg;
  localparam int ADDR_W = 17;
  localparam int DATA_W = 32;
  localparam int WEN_W  = 4;

  typedef enum logic {HOST = 1'b0, COMP = 1'b1} req_id_e;

  typedef struct packed {
    logic    vld;
    req_id_e owner;
  } rd_tag_t;

  typedef struct packed {
    logic [ADDR_W-1:0] addr;
    logic [WEN_W-1:0]  wen;
    logic [DATA_W-1:0] wdata;
  } mem_req_t;
endpackage

// File: rtl/mlaccel_rdpipe.sv
// Fixed-depth delay line of {valid, owner} read tags with synchronous clear.
module mlaccel_rdpipe
  import mlaccel_pkg::*;
#(
  parameter int DEPTH = 1
) (
  input  logic    clock_i,
  input  logic    clr_i,
  input  rd_tag_t tag_i,
  output rd_tag_t tag_o
);
  rd_tag_t [DEPTH-1:0] tag_q;

  always_ff @(posedge clock_i) begin
    if (clr_i) begin
      tag_q <= '0;
    end else begin
      tag_q[0] <= tag_i;
      for (int i = 1; i < DEPTH; i++) tag_q[i] <= tag_q[i-1];
    end
  end

  assign tag_o = tag_q[DEPTH-1];
endmodule

// File: rtl/mlaccel_memarb.sv
// Two-requester (host, compute) single-port memory arbiter with alternating
// tie-break and pipelined read-return routing.
module mlaccel_memarb
  import mlaccel_pkg::*;
#(
  parameter int RD_LATENCY = 1
) (
  input  logic              clock_i,
  input  logic              reset_i,
  input  logic              host_valid_i,
  output logic              host_ready_o,
  input  logic [ADDR_W-1:0] host_addr_i,
  input  logic [WEN_W-1:0]  host_wen_i,
  input  logic [DATA_W-1:0] host_wdata_i,
  output logic              host_rvalid_o,
  output logic [DATA_W-1:0] host_rdata_o,
  input  logic              comp_valid_i,
  output logic              comp_ready_o,
  input  logic [ADDR_W-1:0] comp_addr_i,
  input  logic [WEN_W-1:0]  comp_wen_i,
  input  logic [DATA_W-1:0] comp_wdata_i,
  output logic              comp_rvalid_o,
  output logic [DATA_W-1:0] comp_rdata_o,
  output logic [ADDR_W-1:0] mem_addr_o,
  output logic [WEN_W-1:0]  mem_wen_o,
  output logic [DATA_W-1:0] mem_wdata_o,
  input  logic [DATA_W-1:0] mem_rdata_i
);
  req_id_e  last_grant_q, last_grant_d;
  req_id_e  grant;
  logic     host_wins_tie, issue;
  mem_req_t mem_req;
  rd_tag_t  issue_tag, ret_tag;

  // On a tie the requester that did not win the last issue goes first.
  assign host_wins_tie = (last_grant_q == COMP);
  assign host_ready_o  = !reset_i && host_valid_i && (!comp_valid_i || host_wins_tie);
  assign comp_ready_o  = !reset_i && comp_valid_i && (!host_valid_i || !host_wins_tie);
  assign issue         = host_ready_o || comp_ready_o;
  assign grant         = comp_ready_o ? COMP : HOST;

  always_comb begin
    mem_req = '0;
    if (host_ready_o)      mem_req = '{addr: host_addr_i, wen: host_wen_i, wdata: host_wdata_i};
    else if (comp_ready_o) mem_req = '{addr: comp_addr_i, wen: comp_wen_i, wdata: comp_wdata_i};
  end

  assign mem_addr_o  = mem_req.addr;
  assign mem_wen_o   = mem_req.wen;
  assign mem_wdata_o = mem_req.wdata;

  always_comb begin
    last_grant_d = last_grant_q;
    if (issue) last_grant_d = grant;
  end

  always_ff @(posedge clock_i) begin
    if (reset_i) last_grant_q <= COMP;
    else         last_grant_q <= last_grant_d;
  end

  assign issue_tag.vld   = issue && (mem_req.wen == '0);
  assign issue_tag.owner = grant;

  mlaccel_rdpipe #(.DEPTH(RD_LATENCY)) u_rdpipe (
    .clock_i (clock_i),
    .clr_i   (reset_i),
    .tag_i   (issue_tag),
    .tag_o   (ret_tag)
  );

  // Returns landing during reset are suppressed; the pipe clears on the same edge.
  assign host_rvalid_o = !reset_i && ret_tag.vld && (ret_tag.owner == HOST);
  assign comp_rvalid_o = !reset_i && ret_tag.vld && (ret_tag.owner == COMP);
  assign host_rdata_o  = host_rvalid_o ? mem_rdata_i : '0;
  assign comp_rdata_o  = comp_rvalid_o ? mem_rdata_i : '0;
endmodule

// File: tb/tb_mlaccel_memarb.sv
// Drives RD_LATENCY=1 and RD_LATENCY=3 arbiters with identical stimulus and
// checks both against a transaction-level model of grants, memory and returns.
module tb_mlaccel_memarb;
  logic        clk = 1'b0;
  logic        rst;
  logic        hv, cv;
  logic [16:0] ha, ca;
  logic [3:0]  hw, cw;
  logic [31:0] hd, cd;
  logic        mem_clr;

  logic        h_rdy [2], c_rdy [2], h_rv [2], c_rv [2];
  logic [31:0] h_rd [2], c_rd [2], m_wd [2], m_rd [2];
  logic [16:0] m_a [2];
  logic [3:0]  m_w [2];

  always #5 clk = ~clk;

  function automatic int lat(input int k);
    return (k == 0) ? 1 : 3;
  endfunction

  mlaccel_memarb #(.RD_LATENCY(1)) u_dut1 (
    .clock_i(clk), .reset_i(rst),
    .host_valid_i(hv), .host_ready_o(h_rdy[0]), .host_addr_i(ha), .host_wen_i(hw),
    .host_wdata_i(hd), .host_rvalid_o(h_rv[0]), .host_rdata_o(h_rd[0]),
    .comp_valid_i(cv), .comp_ready_o(c_rdy[0]), .comp_addr_i(ca), .comp_wen_i(cw),
    .comp_wdata_i(cd), .comp_rvalid_o(c_rv[0]), .comp_rdata_o(c_rd[0]),
    .mem_addr_o(m_a[0]), .mem_wen_o(m_w[0]), .mem_wdata_o(m_wd[0]), .mem_rdata_i(m_rd[0]));

  mlaccel_memarb #(.RD_LATENCY(3)) u_dut3 (
    .clock_i(clk), .reset_i(rst),
    .host_valid_i(hv), .host_ready_o(h_rdy[1]), .host_addr_i(ha), .host_wen_i(hw),
    .host_wdata_i(hd), .host_rvalid_o(h_rv[1]), .host_rdata_o(h_rd[1]),
    .comp_valid_i(cv), .comp_ready_o(c_rdy[1]), .comp_addr_i(ca), .comp_wen_i(cw),
    .comp_wdata_i(cd), .comp_rvalid_o(c_rv[1]), .comp_rdata_o(c_rd[1]),
    .mem_addr_o(m_a[1]), .mem_wen_o(m_w[1]), .mem_wdata_o(m_wd[1]), .mem_rdata_i(m_rd[1]));

  // Behavioural memories: read old contents, return them after the instance latency.
  logic [31:0] emem  [2][16];
  logic [31:0] epipe [2][4];

  always @(posedge clk) begin
    for (int k = 0; k < 2; k++) begin
      for (int i = 3; i > 0; i--) epipe[k][i] <= epipe[k][i-1];
      epipe[k][0] <= emem[k][m_a[k][3:0]];
      if (mem_clr) begin
        for (int i = 0; i < 16; i++) emem[k][i] <= 32'h0;
      end else begin
        for (int b = 0; b < 4; b++)
          if (m_w[k][b]) emem[k][m_a[k][3:0]][b*8 +: 8] <= m_wd[k][b*8 +: 8];
      end
    end
  end

  assign m_rd[0] = epipe[0][0];
  assign m_rd[1] = epipe[1][2];

  int n_chk = 0, n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
  endtask

  // Reference model state
  typedef struct {
    int          issue;
    int          owner;
    logic [31:0] data;
  } rd_exp_t;

  rd_exp_t     q[$];
  logic [31:0] ref_mem [16];
  int          last_g;
  int          cyc = 0;
  int          waitc [2];
  int          h_rv_run = 0, h_rv_max = 0;

  task automatic step(input logic r, input logic hv_i, input logic [16:0] ha_i,
                      input logic [3:0] hw_i, input logic [31:0] hd_i,
                      input logic cv_i, input logic [16:0] ca_i,
                      input logic [3:0] cw_i, input logic [31:0] cd_i);
    int          g;
    logic [16:0] ea;
    logic [3:0]  ew;
    logic [31:0] ed;
    @(negedge clk);
    rst = r; hv = hv_i; ha = ha_i; hw = hw_i; hd = hd_i;
    cv = cv_i; ca = ca_i; cw = cw_i; cd = cd_i;
    #1;
    // -1 none, 0 host, 1 comp
    if (r)               g = -1;
    else if (hv && cv)   g = (last_g == 1) ? 0 : 1;
    else if (hv)         g = 0;
    else if (cv)         g = 1;
    else                 g = -1;
    ea = (g == 0) ? ha : (g == 1) ? ca : 17'h0;
    ew = (g == 0) ? hw : (g == 1) ? cw : 4'h0;
    ed = (g == 0) ? hd : (g == 1) ? cd : 32'h0;
    for (int k = 0; k < 2; k++) begin
      logic        ehv, ecv;
      logic [31:0] ehd, ecd;
      ehv = 0; ecv = 0; ehd = 0; ecd = 0;
      if (!r)
        foreach (q[i])
          if (q[i].issue + lat(k) == cyc) begin
            if (q[i].owner == 0) begin ehv = 1; ehd = q[i].data; end
            else                 begin ecv = 1; ecd = q[i].data; end
          end
      chk("host_ready", h_rdy[k], g == 0);
      chk("comp_ready", c_rdy[k], g == 1);
      chk("mem_addr",   m_a[k],   ea);
      chk("mem_wen",    m_w[k],   ew);
      chk("mem_wdata",  m_wd[k],  ed);
      chk("host_rvalid", h_rv[k], ehv);
      chk("host_rdata",  h_rd[k], ehd);
      chk("comp_rvalid", c_rv[k], ecv);
      chk("comp_rdata",  c_rd[k], ecd);
    end
    // A requester left waiting must be served on the following cycle.
    if (!r) begin
      waitc[0] = (hv && !h_rdy[0]) ? waitc[0] + 1 : 0;
      waitc[1] = (cv && !c_rdy[0]) ? waitc[1] + 1 : 0;
      if (hv) chk("fair_host", waitc[0] < 2, 1'b1);
      if (cv) chk("fair_comp", waitc[1] < 2, 1'b1);
    end else begin
      waitc[0] = 0; waitc[1] = 0;
    end
    h_rv_run = h_rv[0] ? h_rv_run + 1 : 0;
    if (h_rv_run > h_rv_max) h_rv_max = h_rv_run;
    // Model update for the coming edge
    if (g >= 0) begin
      last_g = g;
      if (ew == 4'h0) q.push_back('{issue: cyc, owner: g, data: ref_mem[ea[3:0]]});
      else
        for (int b = 0; b < 4; b++) if (ew[b]) ref_mem[ea[3:0]][b*8 +: 8] = ed[b*8 +: 8];
    end
    if (r) begin
      q.delete();
      last_g = 1;
    end
    while (q.size() > 0 && q[0].issue + 3 < cyc) void'(q.pop_front());
    cyc++;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(0, 0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; hv = 0; cv = 0; ha = 0; ca = 0; hw = 0; cw = 0; hd = 0; cd = 0;
    mem_clr = 1;
    last_g = 1;
    waitc[0] = 0; waitc[1] = 0;
    for (int i = 0; i < 16; i++) ref_mem[i] = 32'h0;
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    mem_clr = 0;

    // Host fill then back-to-back read-back
    for (int a = 0; a < 16; a++) step(0, 1, 17'(a), 4'hF, 32'(a), 0, 0, 0, 0);
    h_rv_max = 0;
    for (int a = 0; a < 16; a++) step(0, 1, 17'(a), 4'h0, 0, 0, 0, 0, 0);
    idle(4);
    chk("readback_run", h_rv_max, 16);

    // Both reading continuously: alternating grants, routed returns
    step(1, 0, 0, 0, 0, 0, 0, 0, 0);
    for (int i = 0; i < 8; i++) step(0, 1, 17'(i), 4'h0, 0, 1, 17'(i + 8), 4'h0, 0);
    idle(4);

    // Single-byte compute write while host idle
    step(0, 0, 0, 0, 0, 1, 17'd5, 4'b0001, 32'hDEADBEEF);
    idle(4);

    // Read then write same address: read sees pre-write data
    step(0, 1, 17'd7, 4'h0, 0, 0, 0, 0, 0);
    step(0, 0, 0, 0, 0, 1, 17'd7, 4'hF, 32'h12345678);
    idle(4);

    // Reset right after three reads drops them; next read works
    for (int i = 0; i < 3; i++) step(0, 1, 17'(i), 4'h0, 0, 0, 0, 0, 0);
    step(1, 1, 17'd3, 4'h0, 0, 1, 17'd4, 4'h0, 0);
    idle(5);
    step(0, 1, 17'd9, 4'h0, 0, 0, 0, 0, 0);
    idle(5);

    // Randomized traffic
    for (int i = 0; i < 600; i++) begin
      step(($urandom_range(63) == 0),
           1'($urandom_range(1)), 17'($urandom_range(15)),
           ($urandom_range(1) != 0) ? 4'h0 : 4'($urandom_range(15)), $urandom,
           1'($urandom_range(1)), 17'($urandom_range(15)),
           ($urandom_range(1) != 0) ? 4'h0 : 4'($urandom_range(15)), $urandom);
    end
    idle(5);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
